// File: rtl/posit_op_scheduler.sv
// Round-robin front end that serialises two requesters onto one posit_top; rsp_valid rises >= 3 cycles after accept.
// Backpressure: a stalled response (rsp_ready low) holds every rsp_* field and keeps both request readies low.
module posit_op_scheduler #(
  parameter int posit_width = 8,
  parameter int es          = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [1:0]             req0_opcode,
  input  logic [posit_width-1:0] req0_a,
  input  logic [posit_width-1:0] req0_b,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [1:0]             req1_opcode,
  input  logic [posit_width-1:0] req1_a,
  input  logic [posit_width-1:0] req1_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [posit_width-1:0] rsp_result,
  output logic                   rsp_zero,
  output logic                   rsp_timeout,
  output logic                   pu_start,
  output logic [1:0]             pu_opcode,
  output logic [posit_width-1:0] pu_a,
  output logic [posit_width-1:0] pu_b,
  input  logic                   pu_done,
  input  logic                   pu_zero,
  input  logic [posit_width-1:0] pu_result,
  output logic                   busy
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("posit_op_scheduler: TIMEOUT out of range");
  end
  if (es < 0 || es >= posit_width) begin : g_bad_es
    $error("posit_op_scheduler: es out of range");
  end

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;

  state_t      state;
  logic        rr_ptr;
  logic [15:0] wd_cnt;
  logic        grant_any;
  logic        grant_id;

  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = rr_ptr;
    else                          grant_id = req1_valid;
  end

  assign req0_ready = (state == IDLE) && grant_any && !grant_id;
  assign req1_ready = (state == IDLE) && grant_any &&  grant_id;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      wd_cnt      <= '0;
      pu_start    <= 1'b0;
      pu_opcode   <= '0;
      pu_a        <= '0;
      pu_b        <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      pu_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            pu_opcode <= grant_id ? req1_opcode : req0_opcode;
            pu_a      <= grant_id ? req1_a      : req0_a;
            pu_b      <= grant_id ? req1_b      : req0_b;
            rsp_id    <= grant_id;
            rr_ptr    <= ~grant_id;
            pu_start  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // The start cycle itself is charged to the watchdog budget.
          wd_cnt <= 16'd1;
          state  <= WAIT;
        end
        WAIT: begin
          wd_cnt <= wd_cnt + 16'd1;
          if (pu_done) begin
            state <= CAPTURE;
          end else if (wd_cnt == WD_LAST) begin
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        CAPTURE: begin
          rsp_result  <= pu_result;
          rsp_zero    <= pu_zero;
          rsp_timeout <= 1'b0;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_one_ready: assert property (@(posedge clk) disable iff (reset) !(req0_ready && req1_ready));
  a_start_pulse: assert property (@(posedge clk) disable iff (reset) pu_start |=> !pu_start);

endmodule

// File: doc/posit_op_scheduler.md
Name: posit_op_scheduler

Overview:
- Two-requester round-robin front end for the shared posit_top arithmetic unit.
- Accepts operations (opcode, a, b) from two independent valid/ready requesters and grants one at a time.
- Sequences posit_top's start/done handshake and returns result, zero flag and requester ID on a single valid/ready response channel.
- Includes a watchdog so a hung datapath cannot lock the shared unit.

Parameters:
posit_width, 8, width of posit operands and result
es, 1, exponent size; pass-through only, kept for configuration consistency with posit_top
TIMEOUT, 64, maximum cycles spent in WAIT before the operation is aborted; legal range 2..65535

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_opcode  in  2  requester 0 opcode (2'b11 = divide, same encoding as posit_top)
req0_a  in  posit_width  requester 0 operand a
req0_b  in  posit_width  requester 0 operand b
req1_valid, req1_ready, req1_opcode, req1_a, req1_b  same as requester 0, for requester 1
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the operation
rsp_result  out  posit_width  captured posit_top result
rsp_zero  out  1  captured posit_top zero flag
rsp_timeout  out  1  operation aborted by watchdog
pu_start  out  1  start pulse to posit_top
pu_opcode  out  2  opcode to posit_top
pu_a  out  posit_width  operand a to posit_top
pu_b  out  posit_width  operand b to posit_top
pu_done  in  1  posit_top done
pu_zero  in  1  posit_top zero flag
pu_result  in  posit_width  posit_top result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, dominant over all other inputs, including mid-operation):
  - state goes to IDLE; rr pointer goes to 0.
  - All outputs, operand registers and response registers go to 0.
  - A posit_top operation in flight is abandoned and its later pu_done is ignored.
- FSM states:
  - IDLE:
    - Grant is combinational. If exactly one reqN_valid is high, that requester wins.
    - If both are high, the requester equal to the rr pointer wins.
    - reqN_ready = (state==IDLE) && grant==N. At most one ready is high per cycle.
    - On handshake: latch opcode, a, b and id into pu_* and rsp_id registers; set pointer = ~id; go to ISSUE.
  - ISSUE:
    - pu_start=1 for exactly this one cycle.
    - Clear the watchdog counter; go to WAIT.
  - WAIT:
    - pu_opcode, pu_a and pu_b stay stable.
    - Counter increments each cycle.
    - If pu_done is sampled high, go to CAPTURE.
    - Otherwise, if counter == TIMEOUT-1: set rsp_result=0, rsp_zero=0, rsp_timeout=1, and go to RESP.
    - If pu_done arrives in the same cycle the counter reaches TIMEOUT-1, done wins (no timeout).
  - CAPTURE:
    - Lasts one cycle. posit_top's result is valid the cycle after done.
    - Register pu_result into rsp_result and pu_zero into rsp_zero; set rsp_timeout=0; go to RESP.
  - RESP:
    - rsp_valid=1 and all rsp_* fields held stable until rsp_ready is sampled high.
    - On that edge, rsp_valid drops to 0 and the FSM goes to IDLE.
    - A new grant is possible on the following cycle.
- pu_done outside WAIT is ignored.
- Request inputs are ignored while busy; reqN_ready=0 while busy.
- Latency: accept edge → pu_start (1 cycle) → N posit_top cycles → CAPTURE (1) → rsp_valid.
  - Minimum: rsp_valid 3 cycles after accept when done returns 1 cycle after start.
- Throughput: one operation in flight at a time; no queueing.
- Fairness: with both requesters valid continuously, grants strictly alternate 0,1,0,1…

Test Plan:
- Single divide: req0 opcode=2'b11, a=8'h50 (2.0), b=8'h40 (1.0), rsp_ready=1 → exactly one pu_start pulse; rsp_valid with rsp_id=0, rsp_result=8'h50, rsp_zero=0, rsp_timeout=0.
- Contention: req0 (8'h40 / 8'h50) and req1 (8'h50 / 8'h40) both valid from reset release → req0 granted first, result 8'h30; req1 granted next, result 8'h50. Grants alternate over 6 back-to-back operations.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid → rsp_* fields stable, busy=1, req ready stays 0; response completes the cycle rsp_ready rises.
- Timeout: stub posit_top never asserts done, TIMEOUT=8 → rsp_valid exactly 8 cycles after pu_start with rsp_timeout=1 and rsp_result=0; a late pu_done is ignored and the next request completes normally.
- Reset mid-operation: assert reset in WAIT → next cycle state IDLE, busy=0, rsp_valid=0, pu_start=0; the stale pu_done is ignored and a fresh req1 op completes correctly.
- Zero result: req1 a=8'h00, b=8'h40 → rsp_result=8'h00, rsp_zero=1, rsp_id=1.
